// File: rtl/fft_ram_reader_pkg.sv
// Shared definitions for the FFT RAM readout block.
// Contents:
//   fftState_e  - readout FSM state encoding (exposed on the oSTATE debug port)
//   FIFO_DEPTH  - depth of the output skid FIFO
//   fftLen()    - transform length N = 4 << A_BIT
//   bitReverse()- reverse the low 'width' bits of a value
package fft_ram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } fftState_e;

    localparam int FIFO_DEPTH = 2;

    function automatic int fftLen(input int aBit);
        return 4 << aBit;
    endfunction

    // Reverse all 32 bits, then shift the reversed field down so only the
    // low 'width' bits of the input end up reversed in place.
    function automatic logic [31:0] bitReverse(input logic [31:0] v, input int width);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r >> (32 - width);
    endfunction

endpackage

// File: rtl/fft_skid_fifo.sv
// Small output FIFO that absorbs the one-clock RAM latency when the
// downstream consumer stalls. DEPTH must be a power of two (pointers wrap
// naturally).
// Ports:
//   clk, rstN            - clock, asynchronous active-low reset
//   pushValid, pushData  - write side (a push into a full FIFO is dropped
//                          unless a pop happens in the same cycle)
//   popValid, popReady   - read side handshake, transfer when both high
//   popData              - head entry, stable while popValid && !popReady
//   count                - current occupancy
module fft_skid_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         pushValid,
    input  logic [WIDTH-1:0]             pushData,
    input  logic                         popReady,
    output logic                         popValid,
    output logic [WIDTH-1:0]             popData,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic             doPush;
    logic             doPop;

    assign popValid = (count != '0);
    assign popData  = mem[rdPtr];
    assign doPop    = popValid && popReady;
    assign doPush   = pushValid && ((count != FULL) || doPop);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= wrPtr + PW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fft_ram_reader.sv
// Streams all N = 4*2^A_BIT complex samples out of four RAM banks, in
// natural or bit-reversed order. Sample k lives in bank k[1:0] at address
// k[A_BIT+1:2]; all banks receive the same address and the bank select is
// delayed one clock to pick the matching bank's read data.
// Ports:
//   iCLK, iRST_N              - clock, asynchronous active-low reset
//   iSTART, iBITREV           - start pulse; read order sampled with it
//   oADDR_RD_0..3             - bank read addresses (identical)
//   iDATA_RE_0..3/IM_0..3     - bank read data, one clock after address
//   oDATA_RE, oDATA_IM        - output sample
//   oVALID, iREADY            - output stream handshake
//   oBUSY, oDONE              - run in progress / pulse after last transfer
//   oSTATE                    - FSM state, debug visibility
// Handshake: a sample transfers on every rising edge where oVALID and
// iREADY are both high; oVALID never drops and oDATA never changes until
// the sample it presents has transferred.
module fft_ram_reader
    import fft_ram_reader_pkg::*;
#(
    parameter int D_BIT = 17,
    parameter int A_BIT = 9
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iSTART,
    input  logic             iBITREV,
    output logic [A_BIT-1:0] oADDR_RD_0,
    output logic [A_BIT-1:0] oADDR_RD_1,
    output logic [A_BIT-1:0] oADDR_RD_2,
    output logic [A_BIT-1:0] oADDR_RD_3,
    input  logic [D_BIT-1:0] iDATA_RE_0,
    input  logic [D_BIT-1:0] iDATA_RE_1,
    input  logic [D_BIT-1:0] iDATA_RE_2,
    input  logic [D_BIT-1:0] iDATA_RE_3,
    input  logic [D_BIT-1:0] iDATA_IM_0,
    input  logic [D_BIT-1:0] iDATA_IM_1,
    input  logic [D_BIT-1:0] iDATA_IM_2,
    input  logic [D_BIT-1:0] iDATA_IM_3,
    output logic [D_BIT-1:0] oDATA_RE,
    output logic [D_BIT-1:0] oDATA_IM,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [1:0]       oSTATE
);

    localparam int IDX_W = A_BIT + 2;
    localparam int N     = fftLen(A_BIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    fftState_e         state;
    fftState_e         stateNext;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  revIdx;
    logic [IDX_W-1:0]  rdIdx;
    logic              bitRevQ;
    logic              bitRevSel;
    logic              inFlight;
    logic [1:0]        bankQ;
    logic [1:0]        fifoCount;
    logic [2:0]        occ;
    logic              issue;
    logic              pop;
    logic              lastXfer;
    logic [2*D_BIT-1:0] pushData;
    logic [2*D_BIT-1:0] popData;

    // The start cycle itself issues index 0, before bitRevQ is loaded, so
    // the live iBITREV is used while idle.
    assign bitRevSel = (state == ST_IDLE) ? iBITREV : bitRevQ;
    assign revIdx    = IDX_W'(bitReverse(32'(idx), IDX_W));
    assign rdIdx     = bitRevSel ? revIdx : idx;

    assign oADDR_RD_0 = rdIdx[IDX_W-1:2];
    assign oADDR_RD_1 = rdIdx[IDX_W-1:2];
    assign oADDR_RD_2 = rdIdx[IDX_W-1:2];
    assign oADDR_RD_3 = rdIdx[IDX_W-1:2];

    assign pop = oVALID && iREADY;
    // Occupancy seen by the issue decision: entries left after this cycle's
    // pop plus the read already on its way back from the RAM. Counting the
    // pop keeps full throughput with iREADY high.
    assign occ = {1'b0, fifoCount} + {2'b00, inFlight} - {2'b00, pop};

    always_comb begin
        stateNext = state;
        issue     = 1'b0;
        lastXfer  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iSTART) begin
                    issue     = 1'b1;
                    stateNext = ST_READ;
                end
            end
            ST_READ: begin
                if (occ < 3'd2) begin
                    issue = 1'b1;
                    if (idx == LAST_IDX) begin
                        stateNext = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inFlight && (fifoCount == 2'd1) && pop) begin
                    lastXfer  = 1'b1;
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= ST_IDLE;
            idx      <= '0;
            bitRevQ  <= 1'b0;
            inFlight <= 1'b0;
            bankQ    <= 2'd0;
            oDONE    <= 1'b0;
        end else begin
            state    <= stateNext;
            inFlight <= issue;
            oDONE    <= lastXfer;
            if (issue) begin
                bankQ <= rdIdx[1:0];
            end
            if ((state == ST_IDLE) && iSTART) begin
                bitRevQ <= iBITREV;
            end
            // Index saturates at N-1 and is rearmed only when the run ends.
            if (lastXfer) begin
                idx <= '0;
            end else if (issue && (idx != LAST_IDX)) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        pushData = '0;
        case (bankQ)
            2'd0: pushData = {iDATA_RE_0, iDATA_IM_0};
            2'd1: pushData = {iDATA_RE_1, iDATA_IM_1};
            2'd2: pushData = {iDATA_RE_2, iDATA_IM_2};
            2'd3: pushData = {iDATA_RE_3, iDATA_IM_3};
            default: pushData = '0;
        endcase
    end

    fft_skid_fifo #(
        .WIDTH (2*D_BIT),
        .DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk       (iCLK),
        .rstN      (iRST_N),
        .pushValid (inFlight),
        .pushData  (pushData),
        .popReady  (iREADY),
        .popValid  (oVALID),
        .popData   (popData),
        .count     (fifoCount)
    );

    assign oDATA_RE = popData[2*D_BIT-1:D_BIT];
    assign oDATA_IM = popData[D_BIT-1:0];
    assign oBUSY    = (state != ST_IDLE);
    assign oSTATE   = state;

endmodule

// File: tb/tb_fft_ram_reader.sv
// Self-checking bench for fft_ram_reader at A_BIT=2 (N=16). The RAM model
// holds RE=4a+b, IM=-(4a+b) in bank b at address a, with one clock latency.
module tb_fft_ram_reader;

    localparam int D_BIT = 17;
    localparam int A_BIT = 2;
    localparam int N     = 16;

    logic             iCLK    = 1'b0;
    logic             iRST_N  = 1'b0;
    logic             iSTART  = 1'b0;
    logic             iBITREV = 1'b0;
    logic             iREADY  = 1'b1;
    logic [A_BIT-1:0] addr  [4];
    logic [D_BIT-1:0] ramRe [4];
    logic [D_BIT-1:0] ramIm [4];
    logic [D_BIT-1:0] oDATA_RE;
    logic [D_BIT-1:0] oDATA_IM;
    logic             oVALID;
    logic             oBUSY;
    logic             oDONE;
    logic [1:0]       oSTATE;

    int vecCnt    = 0;
    int errCnt    = 0;
    int xferCnt   = 0;
    int doneCnt   = 0;
    int cyc       = 0;
    int readyMode = 0;
    int xBase     = 0;
    int dBase     = 0;

    logic [D_BIT-1:0] expQ [$];

    // ---------------- clock ----------------
    always #5 iCLK = ~iCLK;

    // ---------------- DUT ----------------
    fft_ram_reader #(.D_BIT(D_BIT), .A_BIT(A_BIT)) dut (
        .iCLK       (iCLK),
        .iRST_N     (iRST_N),
        .iSTART     (iSTART),
        .iBITREV    (iBITREV),
        .oADDR_RD_0 (addr[0]),
        .oADDR_RD_1 (addr[1]),
        .oADDR_RD_2 (addr[2]),
        .oADDR_RD_3 (addr[3]),
        .iDATA_RE_0 (ramRe[0]),
        .iDATA_RE_1 (ramRe[1]),
        .iDATA_RE_2 (ramRe[2]),
        .iDATA_RE_3 (ramRe[3]),
        .iDATA_IM_0 (ramIm[0]),
        .iDATA_IM_1 (ramIm[1]),
        .iDATA_IM_2 (ramIm[2]),
        .iDATA_IM_3 (ramIm[3]),
        .oDATA_RE   (oDATA_RE),
        .oDATA_IM   (oDATA_IM),
        .oVALID     (oVALID),
        .iREADY     (iREADY),
        .oBUSY      (oBUSY),
        .oDONE      (oDONE),
        .oSTATE     (oSTATE)
    );

    // ---------------- RAM model, 1-clock latency ----------------
    always @(posedge iCLK) begin
        for (int b = 0; b < 4; b++) begin
            ramRe[b] <= D_BIT'(int'(addr[b]) * 4 + b);
            ramIm[b] <= D_BIT'(0 - (int'(addr[b]) * 4 + b));
        end
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int tbRev4(input int k);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            r = r | (((k >> i) & 1) << (3 - i));
        end
        return r;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic             prevStall;
        logic [D_BIT-1:0] heldRe;
        logic [D_BIT-1:0] heldIm;
        logic [D_BIT-1:0] e;
        logic [D_BIT-1:0] eIm;
        prevStall = 1'b0;
        heldRe    = '0;
        heldIm    = '0;
        forever begin
            @(negedge iCLK);
            if (!iRST_N) begin
                prevStall = 1'b0;
            end else begin
                if (prevStall) begin
                    check("hold_valid", oVALID, 1);
                    check("hold_re", oDATA_RE, heldRe);
                    check("hold_im", oDATA_IM, heldIm);
                end
                if (oVALID && iREADY) begin
                    check("addr_eq", {addr[1], addr[2], addr[3]}, {3{addr[0]}});
                    if (expQ.size() == 0) begin
                        check("extra_xfer", 1, 0);
                    end else begin
                        e   = expQ.pop_front();
                        eIm = D_BIT'(0) - e;
                        check("re", oDATA_RE, e);
                        check("im", oDATA_IM, eIm);
                    end
                    xferCnt++;
                end
                if (oDONE) doneCnt++;
                prevStall = oVALID && !iREADY;
                heldRe    = oDATA_RE;
                heldIm    = oDATA_IM;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge iCLK);
        #1;
        cyc++;
        case (readyMode)
            1:       iREADY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       iREADY = 1'b0;
            default: iREADY = 1'b1;
        endcase
    endtask

    task automatic startRun(input logic br);
        iSTART  = 1'b1;
        iBITREV = br;
        for (int k = 0; k < N; k++) begin
            expQ.push_back(D_BIT'(br ? tbRev4(k) : k));
        end
        xBase = xferCnt;
        dBase = doneCnt;
        tick();
        iSTART  = 1'b0;
        iBITREV = 1'b0;
    endtask

    task automatic waitXfers(input int n, input int budget);
        for (int i = 0; i < budget && (xferCnt - xBase) < n; i++) tick();
        if ((xferCnt - xBase) < n) check("xfer_timeout", xferCnt - xBase, n);
    endtask

    task automatic waitDone(input int budget);
        for (int i = 0; i < budget && doneCnt == dBase; i++) tick();
        if (doneCnt == dBase) check("done_timeout", 0, 1);
        tick();
        tick();
        @(negedge iCLK);
        check("xfers", xferCnt - xBase, N);
        check("done_pulses", doneCnt - dBase, 1);
        check("queue_empty", expQ.size(), 0);
        check("busy_after", oBUSY, 0);
    endtask

    task automatic checkResetOutputs();
        @(negedge iCLK);
        check("rst_valid", oVALID, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_done", oDONE, 0);
        check("rst_re", oDATA_RE, 0);
        check("rst_im", oDATA_IM, 0);
        check("rst_addr", {addr[0], addr[1], addr[2], addr[3]}, 0);
        check("rst_state", oSTATE, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        // Reset state
        repeat (3) tick();
        checkResetOutputs();
        tick();
        iRST_N = 1'b1;
        repeat (2) tick();

        // Test 1: natural order, first valid 2 clocks after start, 1/clk
        readyMode = 0;
        startRun(1'b0);
        @(negedge iCLK);
        check("lat_c1_valid", oVALID, 0);
        check("lat_c1_busy", oBUSY, 1);
        tick();
        @(negedge iCLK);
        check("lat_c2_valid", oVALID, 1);
        for (int i = 1; i < N; i++) begin
            tick();
            @(negedge iCLK);
            check("stream_valid", oVALID, 1);
        end
        waitDone(100);

        // Test 2: bit-reversed order
        repeat (2) tick();
        startRun(1'b1);
        waitDone(100);

        // Test 3: iREADY toggling 1,0,0,1
        repeat (2) tick();
        readyMode = 1;
        startRun(1'b0);
        waitDone(200);
        readyMode = 0;

        // Test 4: long stall right after start
        repeat (2) tick();
        readyMode = 2;
        startRun(1'b0);
        repeat (20) tick();
        @(negedge iCLK);
        check("stall_valid", oVALID, 1);
        check("stall_re", oDATA_RE, 0);
        check("stall_state", oSTATE, 1);
        readyMode = 0;
        waitDone(100);

        // Test 5: reset mid-readout
        repeat (2) tick();
        startRun(1'b0);
        waitXfers(7, 100);
        iRST_N = 1'b0;
        expQ.delete();
        checkResetOutputs();
        repeat (3) tick();
        iRST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge iCLK);
            check("post_rst_valid", oVALID, 0);
        end
        check("post_rst_busy", oBUSY, 0);
        tick();
        startRun(1'b0);
        waitDone(100);

        // Test 6: second start while busy is ignored
        repeat (2) tick();
        startRun(1'b1);
        waitXfers(5, 100);
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        waitDone(100);
        repeat (6) tick();
        @(negedge iCLK);
        check("no_restart_valid", oVALID, 0);
        check("no_restart_busy", oBUSY, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
